hazard_scheduler: RTL and testbench

Pipeline sequencing controller for the five-stage RISC-V core. It decides each cycle whether the front end advances, stalls for a load-use hazard, or is flushed by a taken branch. It freezes the whole pipeline while a multi-cycle data memory access in MEM is outstanding, and drives `NoOp_o` into the Control unit's `NoOp_i` so that bubbles enter ID/EX as all-zero control.

---
 rtl/hazard_scheduler.sv | 101 ++++++++++
 tb/tb_hazard_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and
// global freeze while a multi-cycle data memory access in MEM is outstanding.
module hazard_scheduler #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_Rs1_i,
  input  logic [4:0]  ID_Rs2_i,
  input  logic        ID_BranchTaken_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_Rd_i,
  input  logic        MEM_MemRead_i,
  input  logic        MEM_MemWrite_i,
  input  logic        mem_ack_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic        Flush_o,
  output logic        Stall_o,
  output logic        mem_req_o,
  output logic        mem_err_o,
  output logic [15:0] lu_cnt_o,
  output logic [15:0] mw_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       acc, lu, lu_bump, mw_bump;

  assign acc = MEM_MemRead_i | MEM_MemWrite_i;
  assign lu  = EX_MemRead_i & (EX_Rd_i != 5'd0) &
               ((EX_Rd_i == ID_Rs1_i) | (EX_Rd_i == ID_Rs2_i));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    PCWrite_o    = 1'b0;
    IFIDWrite_o  = 1'b0;
    NoOp_o       = 1'b0;
    Flush_o      = 1'b0;
    Stall_o      = 1'b0;
    mem_req_o    = 1'b0;
    lu_bump      = 1'b0;
    unique case (state)
      RUN: begin
        mem_req_o = acc;
        if (acc && !mem_ack_i) begin
          Stall_o      = 1'b1;
          wait_cnt_nxt = 8'd1;
          state_nxt    = MEM_WAIT;
        end else if (lu) begin
          // Bubble wins over a taken branch; the branch re-resolves next cycle.
          NoOp_o  = 1'b1;
          lu_bump = 1'b1;
        end else begin
          PCWrite_o   = 1'b1;
          IFIDWrite_o = 1'b1;
          Flush_o     = ID_BranchTaken_i;
        end
      end
      MEM_WAIT: begin
        mem_req_o = 1'b1;
        Stall_o   = ~mem_ack_i;
        if (mem_ack_i) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == 8'(MAX_WAIT)) begin
          state_nxt    = ERR;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR: Stall_o = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // Cycles frozen in ERR are not memory-stall cycles.
  assign mw_bump = Stall_o & (state != ERR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_err_o <= 1'b0;
      lu_cnt_o  <= 16'd0;
      mw_cnt_o  <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) mem_err_o <= 1'b1;
      if (lu_bump && lu_cnt_o != 16'hFFFF) lu_cnt_o <= lu_cnt_o + 16'd1;
      if (mw_bump && mw_cnt_o != 16'hFFFF) mw_cnt_o <= mw_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Randomized bench for hazard_scheduler against a cycle-level behavioural model.
module tb_hazard_scheduler;
  localparam int MAXW = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ID_Rs1_i, ID_Rs2_i, EX_Rd_i;
  logic        ID_BranchTaken_i, EX_MemRead_i, MEM_MemRead_i, MEM_MemWrite_i, mem_ack_i;
  logic        PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Stall_o, mem_req_o, mem_err_o;
  logic [15:0] lu_cnt_o, mw_cnt_o;

  int errors = 0;
  int checks = 0;

  // model: waiting on memory, dead after timeout, wait cycles so far, counters
  bit m_wait, m_dead;
  int m_n, m_lu, m_mw;

  hazard_scheduler #(.MAX_WAIT(MAXW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_BranchTaken_i(ID_BranchTaken_i),
    .EX_MemRead_i(EX_MemRead_i), .EX_Rd_i(EX_Rd_i),
    .MEM_MemRead_i(MEM_MemRead_i), .MEM_MemWrite_i(MEM_MemWrite_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .NoOp_o(NoOp_o), .Flush_o(Flush_o),
    .Stall_o(Stall_o), .mem_req_o(mem_req_o), .mem_err_o(mem_err_o),
    .lu_cnt_o(lu_cnt_o), .mw_cnt_o(mw_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic bit hazard();
    return EX_MemRead_i && EX_Rd_i != 5'd0 && (EX_Rd_i == ID_Rs1_i || EX_Rd_i == ID_Rs2_i);
  endfunction

  task automatic model_reset();
    m_wait = 0; m_dead = 0; m_n = 0; m_lu = 0; m_mw = 0;
  endtask

  task automatic clear_in();
    ID_Rs1_i = '0; ID_Rs2_i = '0; EX_Rd_i = '0; ID_BranchTaken_i = 0;
    EX_MemRead_i = 0; MEM_MemRead_i = 0; MEM_MemWrite_i = 0; mem_ack_i = 0;
  endtask

  task automatic compare(input bit full);
    bit a, pcw, ifw, noop, fl, st, req;
    if (!full) return;
    a = MEM_MemRead_i | MEM_MemWrite_i;
    {pcw, ifw, noop, fl, st, req} = '0;
    if (m_dead) st = 1;
    else if (m_wait) begin
      req = 1;
      st  = !mem_ack_i;
    end else begin
      req = a;
      if (a && !mem_ack_i) st = 1;
      else if (hazard()) noop = 1;
      else begin
        pcw = 1; ifw = 1; fl = ID_BranchTaken_i;
      end
    end
    chk("PCWrite", PCWrite_o, pcw);
    chk("IFIDWrite", IFIDWrite_o, ifw);
    chk("NoOp", NoOp_o, noop);
    chk("Flush", Flush_o, fl);
    chk("Stall", Stall_o, st);
    chk("mem_req", mem_req_o, req);
    chk("mem_err", mem_err_o, m_dead);
    chk("lu_cnt", lu_cnt_o, m_lu);
    chk("mw_cnt", mw_cnt_o, m_mw);
  endtask

  // Model state update at a rising edge; inputs are stable across it.
  task automatic advance();
    if (m_dead) return;
    if (m_wait) begin
      if (mem_ack_i) m_wait = 0;
      else begin
        m_mw = sat(m_mw + 1);
        if (m_n == MAXW) begin m_wait = 0; m_dead = 1; end
        else m_n++;
      end
    end else if ((MEM_MemRead_i || MEM_MemWrite_i) && !mem_ack_i) begin
      m_mw = sat(m_mw + 1); m_wait = 1; m_n = 1;
    end else if (hazard()) m_lu = sat(m_lu + 1);
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, returns at next posedge+1.
  task automatic step(input bit full);
    #4;
    compare(full);
    @(posedge clk_i);
    advance();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 0;
    #1;
    model_reset();
    compare(1);
    @(posedge clk_i);
    #1;
    rst_i = 1;
  endtask

  initial begin
    clear_in();
    rst_i = 0;
    model_reset();
    #3;
    chk("rst_pcw", PCWrite_o, 1);
    chk("rst_ifw", IFIDWrite_o, 1);
    chk("rst_stall", Stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_lu", lu_cnt_o, 0);
    compare(1);
    @(posedge clk_i); #1; rst_i = 1;

    // load-use, then rd=0 gives no bubble
    EX_MemRead_i = 1; EX_Rd_i = 5; ID_Rs2_i = 5; step(1);
    chk("lu_cnt_1", lu_cnt_o, 1);
    EX_Rd_i = 0; ID_Rs2_i = 0; step(1);
    chk("lu_rd0", lu_cnt_o, 1);
    // branch alone, then branch with load-use
    clear_in(); ID_BranchTaken_i = 1; step(1);
    EX_MemRead_i = 1; EX_Rd_i = 7; ID_Rs1_i = 7; step(1);
    clear_in(); step(1);

    // memory wait with ack in third wait cycle
    do_reset();
    MEM_MemRead_i = 1; step(1); step(1); step(1);
    mem_ack_i = 1; step(1);
    clear_in();
    chk("mw_cnt_3", mw_cnt_o, 3);
    step(1);
    // zero-wait write
    MEM_MemWrite_i = 1; mem_ack_i = 1; step(1);
    clear_in(); step(1);
    chk("zw_mw", mw_cnt_o, 3);

    // timeout into ERR, ack ignored there
    MEM_MemRead_i = 1;
    for (int i = 0; i < MAXW + 1; i++) step(1);
    mem_ack_i = 1; step(1); step(1);
    chk("err_sticky", mem_err_o, 1);
    chk("err_stall", Stall_o, 1);
    clear_in();
    do_reset();

    // asynchronous reset in the middle of a memory stall
    MEM_MemRead_i = 1; step(1); step(1);
    #2; rst_i = 0; MEM_MemRead_i = 0;
    #1; model_reset();
    chk("arst_req", mem_req_o, 0);
    chk("arst_stall", Stall_o, 0);
    chk("arst_pcw", PCWrite_o, 1);
    compare(1);
    @(posedge clk_i); #1; rst_i = 1;

    // saturation of the bubble counter
    EX_MemRead_i = 1; EX_Rd_i = 3; ID_Rs1_i = 3;
    for (int i = 0; i < 65540; i++) step(i > 65530);
    chk("lu_sat", lu_cnt_o, 16'hFFFF);
    clear_in();
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_dead && $urandom_range(0, 3) == 0) do_reset();
      ID_Rs1_i         = 5'($urandom_range(0, 3));
      ID_Rs2_i         = 5'($urandom_range(0, 3));
      EX_Rd_i          = 5'($urandom_range(0, 3));
      EX_MemRead_i     = ($urandom_range(0, 1) == 1);
      ID_BranchTaken_i = ($urandom_range(0, 9) < 3);
      MEM_MemRead_i    = ($urandom_range(0, 9) < 2);
      MEM_MemWrite_i   = ($urandom_range(0, 9) < 1);
      mem_ack_i        = ($urandom_range(0, 9) < 4);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
